// File: rtl/multicycle_cpu.sv
// multicycle_cpu
//   Small 16-bit-instruction multicycle processor. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and returns to FETCH. HALT parks
//   the machine in HALTED until reset. Instruction memory is loaded through the
//   prog_* port. Register file and data memory are observable through the dbg_*
//   ports.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   run             : allows FETCH to start the next instruction
//   prog_we/addr/data : instruction-memory write port (works in any state)
//   dbg_reg_sel/data  : combinational register-file read
//   dbg_mem_addr/data : combinational data-memory read
//   pc, state       : program counter and FSM state (FETCH=0 .. HALTED=5)
//   retire          : one-cycle pulse per completed instruction
//   halted          : high while in HALTED
module multicycle_cpu #(
    parameter  int DATA_W     = 16,
    parameter  int IMEM_DEPTH = 16,
    parameter  int DMEM_DEPTH = 16,
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [2:0]        dbg_reg_sel,
    output logic [DATA_W-1:0] dbg_reg_data,
    input  logic [DA_W-1:0]   dbg_mem_addr,
    output logic [DATA_W-1:0] dbg_mem_data,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        state,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t state_q, state_d;

    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] rf   [8];

    logic [15:0]       ir;
    logic [DATA_W-1:0] a_q, b_q, d_q, res_q;
    logic [PC_W-1:0]   pc_q;
    logic              retire_q;

    // Instruction fields
    logic [3:0]        op;
    logic [2:0]        rd, rs, rt, shamt;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   jaddr;

    assign op      = ir[15:12];
    assign rd      = ir[11:9];
    assign rs      = ir[8:6];
    assign rt      = ir[5:3];
    assign shamt   = ir[2:0];
    assign imm_ext = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign jaddr   = PC_W'(ir[8:0]);

    // PC candidates; all arithmetic wraps at IMEM_DEPTH by width
    logic [PC_W-1:0] pc_inc, pc_br;
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_br  = pc_inc + imm_ext[PC_W-1:0];

    // Control
    logic              ld_ir, ld_abd, ld_res, rf_we, dm_we, pc_we, retire_d;
    logic [DATA_W-1:0] res_d, alu, dmem_rd;
    logic [PC_W-1:0]   pc_d;

    // res_q doubles as the effective address while in MEM
    assign dmem_rd = dmem[res_q[DA_W-1:0]];

    always_comb begin
        alu = a_q + imm_ext;  // ADDI, LW, SW address
        case (op)
            OP_ADD:  alu = a_q + b_q;
            OP_SUB:  alu = a_q - b_q;
            OP_AND:  alu = a_q & b_q;
            OP_OR:   alu = a_q | b_q;
            OP_SLL:  alu = a_q << shamt;
            OP_SRL:  alu = a_q >> shamt;
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // FSM next state and datapath controls
    always_comb begin
        state_d  = state_q;
        ld_ir    = 1'b0;
        ld_abd   = 1'b0;
        ld_res   = 1'b0;
        res_d    = alu;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        pc_we    = 1'b0;
        pc_d     = pc_inc;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ld_ir   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ld_abd  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_ADDI: begin
                        ld_res  = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ld_res  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_we    = 1'b1;
                        pc_d     = (d_q == a_q) ? pc_br : pc_inc;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_we    = 1'b1;
                        pc_d     = jaddr;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HALT: begin
                        retire_d = 1'b1;
                        state_d  = S_HALTED;
                    end
                    default: begin  // B-E are NOPs
                        pc_we    = 1'b1;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    ld_res  = 1'b1;
                    res_d   = dmem_rd;
                    state_d = S_WB;
                end else begin
                    dm_we    = 1'b1;
                    pc_we    = 1'b1;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALTED: ;
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            res_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            retire_q <= retire_d;
            if (ld_ir)  ir <= imem[pc_q];
            if (ld_abd) begin
                a_q <= rf[rs];
                b_q <= rf[rt];
                d_q <= rf[rd];
            end
            if (ld_res) res_q <= res_d;
            if (pc_we)  pc_q  <= pc_d;
        end
    end

    // Register file; R0 is cleared by reset and never written, so it reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (rf_we && rd != 3'd0) begin
            rf[rd] <= res_q;
        end
    end

    // Instruction memory: written regardless of state or reset
    always_ff @(posedge clk) begin
        if (prog_we) imem[prog_addr] <= prog_data;
    end

    // Data memory: not cleared by reset; a store in MEM is dropped on a reset edge
    always_ff @(posedge clk) begin
        if (!reset && dm_we) dmem[res_q[DA_W-1:0]] <= d_q;
    end

    assign dbg_reg_data = rf[dbg_reg_sel];
    assign dbg_mem_data = dmem[dbg_mem_addr];
    assign pc           = pc_q;
    assign state        = state_q;
    assign retire       = retire_q;
    assign halted       = (state_q == S_HALTED);

endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;

    localparam int DW  = 16;
    localparam int PCW = 4;
    localparam int DAW = 4;

    logic           clk = 1'b0;
    logic           reset, run, prog_we;
    logic [PCW-1:0] prog_addr;
    logic [15:0]    prog_data;
    logic [2:0]     dbg_reg_sel;
    logic [DW-1:0]  dbg_reg_data;
    logic [DAW-1:0] dbg_mem_addr;
    logic [DW-1:0]  dbg_mem_data;
    logic [PCW-1:0] pc;
    logic [2:0]     state;
    logic           retire, halted;

    int checks   = 0;
    int failures = 0;

    // Retire log filled by run_n: cycle stamp and pc seen with each retire pulse
    int             nret;
    int             rt_cyc [64];
    logic [PCW-1:0] rt_pc  [64];

    multicycle_cpu #(.DATA_W(DW), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .run(run),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
        .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
        .pc(pc), .state(state), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] sh);
        return {op, rd, rs, rt, sh};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Write one instruction word; returns at the next falling edge
    task automatic pw(input int a, input logic [15:0] d);
        prog_addr = PCW'(a);
        prog_data = d;
        prog_we   = 1'b1;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_run();
        reset = 1'b0;
        run   = 1'b1;
    endtask

    // Run up to maxc cycles; cyc = cycles to HALTED, or -1 if it never halted
    task automatic run_n(input int maxc, input bit until_halt, output int cyc);
        nret = 0;
        cyc  = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            cyc++;
            if (retire && nret < 64) begin
                rt_cyc[nret] = cyc;
                rt_pc[nret]  = pc;
                nret++;
            end
            if (until_halt && halted) return;
        end
        if (until_halt) cyc = -1;
    endtask

    task automatic rd_reg(input logic [2:0] s, output logic [DW-1:0] v);
        dbg_reg_sel = s;
        #1;
        v = dbg_reg_data;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        hold_reset();
        hold_reset();
        checks++;
        if (state !== 3'd0 || pc !== 4'd0 || retire !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: state=%0d pc=%0d retire=%b halted=%b, want 0/0/0/0",
                     state, pc, retire, halted);
        end
        rd_reg(3'd5, v);
        checks++;
        if (v !== 16'h0) begin
            failures++;
            $display("FAIL reset_reg: R5=%h want 0000", v);
        end
    endtask

    // ADDI/ADDI/ADD/HALT: result, total cycle count, retire count
    task automatic test_prog();
        int cyc;
        logic [DW-1:0] v;
        hold_reset();
        pw(0, enc_i(4'h6, 3'd1, 3'd0, 6'd5));
        pw(1, enc_i(4'h6, 3'd2, 3'd0, 6'd3));
        pw(2, enc_r(4'h0, 3'd3, 3'd1, 3'd2, 3'd0));
        pw(3, 16'hF000);
        release_run();
        run_n(200, 1'b1, cyc);
        checks++;
        if (cyc !== 15) begin
            failures++;
            $display("FAIL prog_cycles: got %0d want 15", cyc);
        end
        checks++;
        if (nret !== 4) begin
            failures++;
            $display("FAIL prog_retires: got %0d want 4", nret);
        end
        rd_reg(3'd3, v);
        checks++;
        if (v !== 16'd8) begin
            failures++;
            $display("FAIL prog_r3: got %h want 0008", v);
        end
        checks++;
        if (pc !== 4'd3 || state !== 3'd5) begin
            failures++;
            $display("FAIL prog_halt: pc=%0d state=%0d want 3/5", pc, state);
        end
        // run is ignored while halted
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 3'd5 || retire !== 1'b0) begin
            failures++;
            $display("FAIL halt_hold: state=%0d retire=%b want 5/0", state, retire);
        end
    endtask

    // Shifts and logic ops on an all-ones word. shamt is 3 bits, so the
    // shift-right-by-15 case is composed as 7+7+1.
    task automatic test_alu();
        int cyc;
        logic [DW-1:0] v;
        logic [DW-1:0] exp_v [8];
        exp_v = '{16'h0, 16'hFFFF, 16'hFFF8, 16'h0001, 16'h01FF, 16'hFFF9, 16'h01F8, 16'hFFF9};
        hold_reset();
        pw(0, enc_i(4'h6, 3'd1, 3'd0, 6'h3F));
        pw(1, enc_r(4'h4, 3'd2, 3'd1, 3'd0, 3'd3));
        pw(2, enc_r(4'h5, 3'd3, 3'd1, 3'd0, 3'd7));
        pw(3, enc_r(4'h5, 3'd3, 3'd3, 3'd0, 3'd7));
        pw(4, enc_r(4'h5, 3'd3, 3'd3, 3'd0, 3'd1));
        pw(5, enc_r(4'h5, 3'd4, 3'd1, 3'd0, 3'd7));
        pw(6, enc_r(4'h1, 3'd5, 3'd2, 3'd1, 3'd0));
        pw(7, enc_r(4'h2, 3'd6, 3'd4, 3'd2, 3'd0));
        pw(8, enc_r(4'h3, 3'd7, 3'd3, 3'd2, 3'd0));
        pw(9, 16'hF000);
        release_run();
        run_n(300, 1'b1, cyc);
        checks++;
        if (cyc !== 39) begin
            failures++;
            $display("FAIL alu_cycles: got %0d want 39", cyc);
        end
        for (int r = 1; r < 8; r++) begin
            rd_reg(3'(r), v);
            checks++;
            if (v !== exp_v[r]) begin
                failures++;
                $display("FAIL alu_r%0d: got %h want %h", r, v, exp_v[r]);
            end
        end
    endtask

    // Build 0x1234 in R1, SW to ea=2, LW back into R4
    task automatic test_mem();
        int cyc;
        logic [DW-1:0] v;
        hold_reset();
        pw(0, enc_i(4'h6, 3'd1, 3'd0, 6'd18));
        pw(1, enc_r(4'h4, 3'd1, 3'd1, 3'd0, 3'd7));
        pw(2, enc_r(4'h4, 3'd1, 3'd1, 3'd0, 3'd1));
        pw(3, enc_i(4'h6, 3'd1, 3'd1, 6'd26));
        pw(4, enc_i(4'h6, 3'd1, 3'd1, 6'd26));
        pw(5, enc_i(4'h6, 3'd5, 3'd0, 6'd1));
        pw(6, enc_i(4'h8, 3'd1, 3'd5, 6'd1));
        pw(7, enc_i(4'h7, 3'd4, 3'd5, 6'd1));
        pw(8, 16'hF000);
        release_run();
        run_n(300, 1'b1, cyc);
        checks++;
        if (cyc !== 36 || nret !== 9) begin
            failures++;
            $display("FAIL mem_cycles: cycles=%0d retires=%0d want 36/9", cyc, nret);
        end
        checks++;
        if (rt_cyc[6] - rt_cyc[5] !== 4) begin
            failures++;
            $display("FAIL sw_latency: got %0d want 4", rt_cyc[6] - rt_cyc[5]);
        end
        checks++;
        if (rt_cyc[7] - rt_cyc[6] !== 5) begin
            failures++;
            $display("FAIL lw_latency: got %0d want 5", rt_cyc[7] - rt_cyc[6]);
        end
        dbg_mem_addr = 4'd2;
        #1;
        checks++;
        if (dbg_mem_data !== 16'h1234) begin
            failures++;
            $display("FAIL sw_dmem2: got %h want 1234", dbg_mem_data);
        end
        rd_reg(3'd4, v);
        checks++;
        if (v !== 16'h1234) begin
            failures++;
            $display("FAIL lw_r4: got %h want 1234", v);
        end
    endtask

    task automatic test_branch();
        int cyc;
        // Taken: JMP 5; at 5 BEQ R0,R0,-2 -> 4; HALT at 4
        hold_reset();
        pw(0, 16'hA005);
        pw(4, 16'hF000);
        pw(5, enc_i(4'h9, 3'd0, 3'd0, 6'h3E));
        release_run();
        run_n(100, 1'b1, cyc);
        checks++;
        if (cyc !== 9 || pc !== 4'd4 || rt_pc[1] !== 4'd4) begin
            failures++;
            $display("FAIL beq_taken: cycles=%0d pc=%0d bpc=%0d want 9/4/4", cyc, pc, rt_pc[1]);
        end
        // Not taken: R1=1 vs R0
        hold_reset();
        pw(0, enc_i(4'h6, 3'd1, 3'd0, 6'd1));
        pw(1, 16'hA005);
        pw(5, enc_i(4'h9, 3'd1, 3'd0, 6'h3E));
        pw(6, 16'hF000);
        release_run();
        run_n(100, 1'b1, cyc);
        checks++;
        if (rt_pc[2] !== 4'd6 || pc !== 4'd6 || cyc !== 13) begin
            failures++;
            $display("FAIL beq_not_taken: bpc=%0d pc=%0d cycles=%0d want 6/6/13", rt_pc[2], pc, cyc);
        end
        // JMP at the last address back to 0
        hold_reset();
        pw(0, 16'hA00E);
        pw(14, 16'hB000);
        pw(15, 16'hA000);
        release_run();
        run_n(12, 1'b0, cyc);
        checks++;
        if (nret !== 4 || rt_pc[0] !== 4'd14 || rt_pc[1] !== 4'd15 || rt_pc[2] !== 4'd0) begin
            failures++;
            $display("FAIL jmp_wrap: n=%0d pcs=%0d,%0d,%0d want 4 14,15,0",
                     nret, rt_pc[0], rt_pc[1], rt_pc[2]);
        end
        // NOP at the last address wraps pc to 0
        hold_reset();
        pw(0, 16'hA00F);
        pw(15, 16'hC000);
        release_run();
        run_n(6, 1'b0, cyc);
        checks++;
        if (nret !== 2 || rt_pc[0] !== 4'd15 || rt_pc[1] !== 4'd0) begin
            failures++;
            $display("FAIL nop_wrap: n=%0d pcs=%0d,%0d want 2 15,0", nret, rt_pc[0], rt_pc[1]);
        end
    endtask

    task automatic test_run_hold();
        int cyc;
        logic [DW-1:0] v;
        hold_reset();
        pw(0, enc_i(4'h6, 3'd1, 3'd0, 6'd5));
        pw(1, enc_i(4'h6, 3'd2, 3'd0, 6'd3));
        pw(2, enc_r(4'h0, 3'd3, 3'd1, 3'd2, 3'd0));
        pw(3, 16'hF000);
        release_run();
        repeat (4) @(negedge clk);
        run = 1'b0;
        run_n(10, 1'b0, cyc);
        rd_reg(3'd1, v);
        checks++;
        if (pc !== 4'd1 || state !== 3'd0 || nret !== 0 || v !== 16'd5) begin
            failures++;
            $display("FAIL run_hold: pc=%0d state=%0d retires=%0d R1=%h want 1/0/0/0005",
                     pc, state, nret, v);
        end
        // Restart and reset in the WB cycle of the ADD
        hold_reset();
        release_run();
        repeat (11) @(negedge clk);
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("FAIL add_in_wb: state=%0d want 4", state);
        end
        reset = 1'b1;
        @(negedge clk);
        rd_reg(3'd3, v);
        checks++;
        if (v !== 16'd0 || pc !== 4'd0 || state !== 3'd0 || retire !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_wb: R3=%h pc=%0d state=%0d retire=%b want 0000/0/0/0",
                     v, pc, state, retire);
        end
    endtask

    task automatic test_r0();
        int cyc;
        logic [DW-1:0] v;
        hold_reset();
        pw(0, enc_i(4'h6, 3'd0, 3'd0, 6'd7));
        pw(1, enc_i(4'h6, 3'd1, 3'd0, 6'd2));
        pw(2, 16'hF000);
        release_run();
        run_n(100, 1'b1, cyc);
        rd_reg(3'd0, v);
        checks++;
        if (v !== 16'd0) begin
            failures++;
            $display("FAIL r0_write: R0=%h want 0000", v);
        end
        rd_reg(3'd1, v);
        checks++;
        if (v !== 16'd2 || cyc !== 11) begin
            failures++;
            $display("FAIL r0_source: R1=%h cycles=%0d want 0002/11", v, cyc);
        end
    endtask

    initial begin
        reset        = 1'b1;
        run          = 1'b0;
        prog_we      = 1'b0;
        prog_addr    = '0;
        prog_data    = '0;
        dbg_reg_sel  = '0;
        dbg_mem_addr = '0;
        test_reset();
        test_prog();
        test_alu();
        test_mem();
        test_branch();
        test_run_hold();
        test_r0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DATA_W, default 16: register, ALU and data-memory word width (minimum 16).
REQ-002 Parameter IMEM_DEPTH, default 16: instruction words, power of two; PC_W = clog2(IMEM_DEPTH).
REQ-003 Parameter DMEM_DEPTH, default 16: data words, power of two; DA_W = clog2(DMEM_DEPTH).
REQ-004 Ports (name  direction  width  meaning):
  clk  in  1  single clock, all state updates on rising edge.
  reset  in  1  synchronous, active-high.
  run  in  1  permits leaving FETCH.
  prog_we  in  1  instruction-memory write strobe.
  prog_addr  in  PC_W  instruction write address.
  prog_data  in  16  instruction write data.
  dbg_reg_sel  in  3  register-file read select.
  dbg_reg_data  out  DATA_W  combinational R[dbg_reg_sel].
  dbg_mem_addr  in  DA_W  data-memory read address.
  dbg_mem_data  out  DATA_W  combinational DMEM[dbg_mem_addr].
  pc  out  PC_W  current program counter.
  state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
  retire  out  1  one-cycle pulse per completed instruction.
  halted  out  1  high while in HALTED.
REQ-005 Clock is clk; reset is reset, synchronous and active-high; one clock domain.

Function
REQ-006 Instruction fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], shamt=[2:0], imm6=[5:0] sign-extended to DATA_W, jaddr=[8:0] truncated to PC_W.
REQ-007 Register file: 8 x DATA_W; R0 reads zero, writes to R0 ignored.
REQ-008 Opcodes: 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR; 4 SLL rd=rs<<shamt; 5 SRL (logical) rd=rs>>shamt; 6 ADDI rd=rs+imm6; 7 LW rd=DMEM[ea]; 8 SW DMEM[ea]=R[rd]; 9 BEQ if R[rd]==R[rs] pc=pc+1+imm6; A JMP pc=jaddr; F HALT; B-E NOP.
REQ-009 Arithmetic modulo 2^DATA_W, no flags; ea = low DA_W bits of (rs+imm6), wraps silently.
REQ-010 PC arithmetic modulo IMEM_DEPTH; pc+1 at IMEM_DEPTH-1 wraps to 0.
REQ-011 FETCH: if run=1 latch IR=IMEM[pc], go DECODE; else hold, no state change.
REQ-012 DECODE: latch A=R[rs], B=R[rt], D=R[rd]; go EXEC.
REQ-013 EXEC: compute ALU result/ea; ALU ops and ADDI -> WB; LW, SW -> MEM; BEQ, JMP, NOP -> update pc, pulse retire, -> FETCH; HALT -> HALTED, pulse retire, pc unchanged.
REQ-014 MEM: LW latches DMEM[ea] -> WB; SW writes D to DMEM[ea], pc=pc+1, pulse retire -> FETCH.
REQ-015 WB: write result to rd, pc=pc+1, pulse retire -> FETCH.
REQ-016 Cycle counts FETCH-to-FETCH (run=1): ALU/ADDI 4, LW 5, SW 4, BEQ/JMP/NOP 3.
REQ-017 BEQ not taken: pc=pc+1.
REQ-018 prog_we writes IMEM[prog_addr]=prog_data at any cycle, any state; a same-cycle FETCH of that address gets the old word.
REQ-019 HALTED: held until reset; run ignored; IMEM, DMEM, registers frozen except prog_we writes.
REQ-020 run deasserted outside FETCH has no effect; the instruction in flight completes.

Reset
REQ-021 reset=1 at an edge: pc=0, state=FETCH, R1-R7=0, IR/A/B/D=0, retire=0, halted=0, from any state including mid-instruction (in-flight WB/MEM writes suppressed that edge).
REQ-022 Reset does not clear IMEM or DMEM; prog_we during reset is honoured.
REQ-023 reset has priority over run, prog_we-to-state effects, and all transitions.

Verification
REQ-024 Load ADDI R1,R0,5; ADDI R2,R0,3; ADD R3,R1,R2; HALT; run=1 -> R3=8, halted at cycle 4+4+4+3=15 after reset release, retire pulses=4.
REQ-025 ADDI R1,R0,-1 (DATA_W=16) then SLL R2,R1,3 and SRL R3,R1,15 -> R1=FFFF, R2=FFF8, R3=0001.
REQ-026 SW R1 to ea=2 then LW R4 from ea=2 with R1=0x1234 -> DMEM[2]=0x1234, R4=0x1234; SW 4 cycles, LW 5 cycles.
REQ-027 BEQ taken with imm6=-2 at pc=5 -> pc=4; not taken -> pc=6; JMP at pc=IMEM_DEPTH-1 with jaddr=0, and NOP at IMEM_DEPTH-1 -> pc=0.
REQ-028 run=0 in FETCH for 10 cycles -> pc, state, registers unchanged, no retire; reset asserted during WB of ADD -> rd stays 0, pc=0, state=FETCH.
REQ-029 Write to R0 via ADDI R0,R0,7 -> dbg_reg_data for sel 0 remains 0.
